// File: rtl/jtopl_pkg.sv
// Shared constants and types for the OPL register write front end:
// register groups, default write-recovery times and the write FSM encoding.
package jtopl_pkg;

  localparam logic [3:0] GRP_A  = 4'hA;
  localparam logic [3:0] GRP_B  = 4'hB;
  localparam logic [3:0] GRP_C  = 4'hC;
  localparam logic [7:0] REG_BD = 8'hBD;
  localparam logic [3:0] MAX_CH = 4'd8;

  localparam int ADDR_WAIT_DEF = 12;
  localparam int DATA_WAIT_DEF = 84;
  localparam int BUSY_W        = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_STRB
  } wr_state_t;

  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_FNUMLO,
    UPD_FNUMHI,
    UPD_FBCON,
    UPD_RHY
  } upd_t;

  // Maps a selected-register byte to the update it triggers on a data write.
  function automatic upd_t decode_sel(input logic [7:0] sel);
    upd_t kind;
    kind = UPD_NONE;
    if (sel == REG_BD) begin
      kind = UPD_RHY;
    end else if (sel[3:0] <= MAX_CH) begin
      case (sel[7:4])
        GRP_A:   kind = UPD_FNUMLO;
        GRP_B:   kind = UPD_FNUMHI;
        GRP_C:   kind = UPD_FBCON;
        default: kind = UPD_NONE;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/jtopl_wr_busy.sv
// Write-recovery counter: loads on an accepted write, then counts down
// once per cen tick; busy is high while the count is nonzero.
module jtopl_wr_busy
  import jtopl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BUSY_W-1:0] load_val,
  input  logic              cen,
  output logic [BUSY_W-1:0] count,
  output logic              busy
);

  localparam logic [BUSY_W-1:0] ONE = BUSY_W'(1);

  logic [BUSY_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      // A load wins over cen, so decrementing starts on the next cen tick.
      r_count <= load_val;
    end else if (cen && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign count = r_count;
  assign busy  = (r_count != '0);

endmodule

// File: rtl/jtopl_reg_wr.sv
// CPU write interface for the OPL register file: latches the register
// select and data, enforces write recovery, and issues one-cen update strobes.
module jtopl_reg_wr
  import jtopl_pkg::*;
#(
  parameter int ADDR_WAIT = ADDR_WAIT_DEF,
  parameter int DATA_WAIT = DATA_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic [3:0] up_ch,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic [7:0] dout,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);

  localparam logic [BUSY_W-1:0] ADDR_CNT = ADDR_WAIT[BUSY_W-1:0];
  localparam logic [BUSY_W-1:0] DATA_CNT = DATA_WAIT[BUSY_W-1:0];

  logic              w_busy;
  logic [BUSY_W-1:0] w_count;
  logic              w_wr;
  logic              w_addr_wr;
  logic              w_data_wr;
  logic [BUSY_W-1:0] w_load_val;
  wr_state_t         w_state_nxt;

  wr_state_t         r_state;
  upd_t              r_kind;
  logic [7:0]        r_sel;
  logic [3:0]        r_up_ch;
  logic [7:0]        r_dout;
  logic              r_rhy_en;
  logic [4:0]        r_rhy_kon;

  // Writes are edge-qualified only by the strobes, not by cen.
  assign w_wr       = !cs_n && !wr_n && !rst && (w_count == '0);
  assign w_addr_wr  = w_wr && !addr;
  assign w_data_wr  = w_wr && addr;
  assign w_load_val = addr ? DATA_CNT : ADDR_CNT;

  jtopl_wr_busy u_busy (
    .clk      (clk),
    .rst      (rst),
    .load     (w_wr),
    .load_val (w_load_val),
    .cen      (cen),
    .count    (w_count),
    .busy     (w_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    up_fnumlo   = 1'b0;
    up_fnumhi   = 1'b0;
    up_fbcon    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_data_wr) w_state_nxt = ST_PEND;
      ST_PEND: if (cen) w_state_nxt = ST_STRB;
      ST_STRB: begin
        up_fnumlo = (r_kind == UPD_FNUMLO);
        up_fnumhi = (r_kind == UPD_FNUMHI);
        up_fbcon  = (r_kind == UPD_FBCON);
        if (cen) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Target channel, data and update kind are frozen at the data write so
  // they stay stable through PEND and STRB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= '0;
      r_kind    <= UPD_NONE;
      r_up_ch   <= '0;
      r_dout    <= '0;
      r_rhy_en  <= 1'b0;
      r_rhy_kon <= '0;
    end else begin
      if (w_addr_wr) begin
        r_sel <= din;
      end
      if (w_data_wr) begin
        r_kind  <= decode_sel(r_sel);
        r_up_ch <= r_sel[3:0];
        r_dout  <= din;
      end
      if ((r_state == ST_PEND) && cen && (r_kind == UPD_RHY)) begin
        r_rhy_en  <= r_dout[5];
        r_rhy_kon <= r_dout[4:0];
      end
    end
  end

  assign busy    = w_busy;
  assign up_ch   = r_up_ch;
  assign dout    = r_dout;
  assign rhy_en  = r_rhy_en;
  assign rhy_kon = r_rhy_kon;

endmodule

// File: tb/tb_jtopl_reg_wr.sv
// Directed bench for jtopl_reg_wr: table of address/data write pairs with
// hand-computed strobe, channel, data and rhythm results, plus corner sequences.
module tb_jtopl_reg_wr;

  localparam int EXP_ADDR_TICKS = 12;
  localparam int EXP_DATA_TICKS = 84;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       cs_n;
  logic       wr_n;
  logic       addr;
  logic [7:0] din;
  logic       busy;
  logic [3:0] up_ch;
  logic       up_fnumlo;
  logic       up_fnumhi;
  logic       up_fbcon;
  logic [7:0] dout;
  logic       rhy_en;
  logic [4:0] rhy_kon;

  jtopl_reg_wr dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .addr      (addr),
    .din       (din),
    .busy      (busy),
    .up_ch     (up_ch),
    .up_fnumlo (up_fnumlo),
    .up_fnumhi (up_fnumhi),
    .up_fbcon  (up_fbcon),
    .dout      (dout),
    .rhy_en    (rhy_en),
    .rhy_kon   (rhy_kon)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       ca;
    logic       cd;
    int         lo;
    int         hi;
    int         fb;
    logic [3:0] ch;
    logic       ren;
    logic [4:0] kon;
  } vec_t;

  vec_t vecs[7];

  int checks   = 0;
  int failures = 0;

  logic cen_next;
  int   n_tick, n_lo, n_hi, n_fb;
  logic [3:0] cap_ch;
  logic [7:0] cap_dout;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] d,
                              input logic ca, input logic cd,
                              input int lo, input int hi, input int fb,
                              input logic [3:0] ch, input logic ren,
                              input logic [4:0] kon);
    vec_t v;
    v.a = a; v.d = d; v.ca = ca; v.cd = cd;
    v.lo = lo; v.hi = hi; v.fb = fb;
    v.ch = ch; v.ren = ren; v.kon = kon;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Samples what the receiver would see at the coming edge, then advances.
  task automatic edge_adv();
    if (cen && busy) n_tick++;
    if (cen && (up_fnumlo || up_fnumhi || up_fbcon)) begin
      cap_ch   = up_ch;
      cap_dout = dout;
    end
    if (cen && up_fnumlo) n_lo++;
    if (cen && up_fnumhi) n_hi++;
    if (cen && up_fbcon)  n_fb++;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cen      = cen_next;
    cen_next = ~cen_next;
    edge_adv();
  endtask

  task automatic write(input logic a, input logic [7:0] d, input logic c);
    cs_n     = 1'b0;
    wr_n     = 1'b0;
    addr     = a;
    din      = d;
    cen      = c;
    cen_next = ~c;
    edge_adv();
    cs_n     = 1'b1;
    wr_n     = 1'b1;
  endtask

  task automatic clr();
    n_tick   = 0;
    n_lo     = 0;
    n_hi     = 0;
    n_fb     = 0;
    cap_ch   = '0;
    cap_dout = '0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000 && busy; k++) step();
    check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = mk(8'hA3, 8'h55, 1'b0, 1'b1, 1, 0, 0, 4'h3, 1'b0, 5'h00);
    vecs[1] = mk(8'hB8, 8'h2F, 1'b1, 1'b0, 0, 1, 0, 4'h8, 1'b0, 5'h00);
    vecs[2] = mk(8'hC9, 8'h07, 1'b0, 1'b0, 0, 0, 0, 4'h9, 1'b0, 5'h00);
    vecs[3] = mk(8'hBD, 8'h3A, 1'b1, 1'b1, 0, 0, 0, 4'hD, 1'b1, 5'h1A);
    vecs[4] = mk(8'hC0, 8'h81, 1'b0, 1'b1, 0, 0, 1, 4'h0, 1'b1, 5'h1A);
    vecs[5] = mk(8'h5F, 8'h12, 1'b1, 1'b0, 0, 0, 0, 4'hF, 1'b1, 5'h1A);
    vecs[6] = mk(8'hA8, 8'hFF, 1'b1, 1'b0, 1, 0, 0, 4'h8, 1'b1, 5'h1A);

    cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = '0;
    cen = 1'b0; cen_next = 1'b1; rst = 1'b1;
    clr();
    repeat (4) step();
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_strobes", {29'd0, up_fnumlo, up_fnumhi, up_fbcon}, 32'd0);
    check("rst_up_ch",   {28'd0, up_ch}, 32'd0);
    check("rst_dout",    {24'd0, dout}, 32'd0);
    check("rst_rhy",     {26'd0, rhy_en, rhy_kon}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      clr();
      write(1'b0, vecs[i].a, vecs[i].ca);
      check($sformatf("v%0d_addr_busy", i), {31'd0, busy}, 32'd1);
      wait_idle();
      check($sformatf("v%0d_addr_ticks", i), n_tick, EXP_ADDR_TICKS);
      clr();
      write(1'b1, vecs[i].d, vecs[i].cd);
      check($sformatf("v%0d_data_busy", i), {31'd0, busy}, 32'd1);
      wait_idle();
      check($sformatf("v%0d_data_ticks", i), n_tick, EXP_DATA_TICKS);
      check($sformatf("v%0d_fnumlo", i), n_lo, vecs[i].lo);
      check($sformatf("v%0d_fnumhi", i), n_hi, vecs[i].hi);
      check($sformatf("v%0d_fbcon", i),  n_fb, vecs[i].fb);
      if (vecs[i].lo + vecs[i].hi + vecs[i].fb != 0) begin
        check($sformatf("v%0d_strb_ch", i),   {28'd0, cap_ch},   {28'd0, vecs[i].ch});
        check($sformatf("v%0d_strb_dout", i), {24'd0, cap_dout}, {24'd0, vecs[i].d});
      end
      check($sformatf("v%0d_up_ch", i),   {28'd0, up_ch}, {28'd0, vecs[i].ch});
      check($sformatf("v%0d_dout", i),    {24'd0, dout},  {24'd0, vecs[i].d});
      check($sformatf("v%0d_rhy_en", i),  {31'd0, rhy_en},  {31'd0, vecs[i].ren});
      check($sformatf("v%0d_rhy_kon", i), {27'd0, rhy_kon}, {27'd0, vecs[i].kon});
    end

    // Writes landing 5 cen ticks into a data write's recovery are dropped.
    clr();
    write(1'b0, 8'hA1, 1'b0);
    wait_idle();
    clr();
    write(1'b1, 8'h44, 1'b1);
    repeat (10) step();
    write(1'b1, 8'h99, 1'b0);
    write(1'b0, 8'hB2, 1'b1);
    wait_idle();
    check("ign_ticks", n_tick, EXP_DATA_TICKS);
    check("ign_lo",    n_lo, 1);
    check("ign_hi",    n_hi, 0);
    check("ign_ch",    {28'd0, cap_ch}, 32'h1);
    check("ign_dout",  {24'd0, dout}, 32'h44);
    clr();
    write(1'b1, 8'h66, 1'b0);
    wait_idle();
    check("ign_sel_lo",   n_lo, 1);
    check("ign_sel_hi",   n_hi, 0);
    check("ign_sel_ch",   {28'd0, cap_ch}, 32'h1);
    check("ign_sel_dout", {24'd0, cap_dout}, 32'h66);

    // Reset while the data write is pending aborts it.
    clr();
    write(1'b0, 8'hA5, 1'b1);
    wait_idle();
    clr();
    write(1'b1, 8'h77, 1'b0);
    check("pend_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    check("prst_busy",    {31'd0, busy}, 32'd0);
    check("prst_strobes", {29'd0, up_fnumlo, up_fnumhi, up_fbcon}, 32'd0);
    check("prst_up_ch",   {28'd0, up_ch}, 32'd0);
    check("prst_dout",    {24'd0, dout}, 32'd0);
    check("prst_rhy",     {26'd0, rhy_en, rhy_kon}, 32'd0);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'hEE;
    step();
    cs_n = 1'b1; wr_n = 1'b1;
    check("rstwr_busy", {31'd0, busy}, 32'd0);
    check("rstwr_dout", {24'd0, dout}, 32'd0);
    rst = 1'b0;
    clr();
    repeat (20) step();
    check("post_rst_strobes", n_lo + n_hi + n_fb, 0);
    check("post_rst_busy",    {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
